// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer: 20-tap symmetric low-pass FIR evaluated one tap per cycle
// on a single shared multiplier, with valid/ready handshakes on both sides.
// Optional feature macro: FIR_WARMUP_BYPASS_EN -- while fewer than DEPTH
// samples have been seen, the current sample is passed through unfiltered.
module fir_mac_sequencer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int PW        = $clog2(DEPTH);
  localparam int KW        = $clog2(DEPTH + 1);
  localparam int AW        = WIDTH + 9;
  localparam int MW        = WIDTH + 5;
  localparam int COEFF_SUM = 250;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] hist [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [KW-1:0]    k;
  logic [AW-1:0]    acc;
  logic [MW-1:0]    prod;
  logic [AW-1:0]    quot;
  logic [WIDTH-1:0] filtered;

  // Fixed tap weights; indices past the last tap weigh zero so the
  // pipeline-drain cycle contributes nothing.
  function automatic logic [4:0] coeff(input int idx);
    case (idx)
      0, 19:   coeff = 5'd1;
      1, 18:   coeff = 5'd2;
      2, 17:   coeff = 5'd3;
      3, 16:   coeff = 5'd5;
      4, 15:   coeff = 5'd8;
      5, 14:   coeff = 5'd12;
      6, 13:   coeff = 5'd17;
      7, 12:   coeff = 5'd22;
      8, 11:   coeff = 5'd26;
      9, 10:   coeff = 5'd29;
      default: coeff = 5'd0;
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake outputs; MAC ends once the drain cycle (k == DEPTH) is done.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = MAC;
      end
      MAC: begin
        if (k == KW'(DEPTH)) state_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // History buffer and MAC datapath: product is registered, so the
  // accumulator trails the tap index by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      k      <= '0;
      acc    <= '0;
      prod   <= '0;
      for (int i = 0; i < DEPTH; i++) hist[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            hist[wr_ptr] <= in_data;
            rd_ptr       <= wr_ptr;
            wr_ptr       <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            acc          <= '0;
            prod         <= '0;
            k            <= '0;
          end
        end
        MAC: begin
          acc    <= acc + AW'(prod);
          prod   <= MW'(hist[rd_ptr]) * MW'(coeff(int'(k)));
          rd_ptr <= (rd_ptr == '0) ? PW'(DEPTH - 1) : rd_ptr - 1'b1;
          k      <= k + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Normalise by the coefficient sum and clamp to the output range.
  always_comb begin
    quot     = acc / AW'(COEFF_SUM);
    filtered = quot[WIDTH-1:0];
    if (quot > AW'((1 << WIDTH) - 1)) filtered = '1;
  end

`ifdef FIR_WARMUP_BYPASS_EN
  logic [KW-1:0]    sample_count;
  logic [WIDTH-1:0] cur_sample;
  logic             bypass;

  // Track warm-up: a result is bypassed if its own sample is among the first DEPTH-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count <= '0;
      cur_sample   <= '0;
      bypass       <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      if (sample_count != KW'(DEPTH)) sample_count <= sample_count + 1'b1;
      cur_sample <= in_data;
      bypass     <= (sample_count < KW'(DEPTH - 1));
    end
  end

  // Select pass-through during warm-up, filtered value afterwards.
  always_comb begin
    out_data = bypass ? cur_sample : filtered;
  end
`else
  // Every result is the filtered value over zero-filled history.
  always_comb begin
    out_data = filtered;
  end
`endif

endmodule
